// File: rtl/spi_ctrl_pkg.sv
// +--------------------------------------------------------------------------+
// | spi_ctrl_pkg : shared state encoding and constants for the SPI initiator |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package spi_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam int BYTE_W            = 8;
  localparam int SPI_NUM_REGS      = 60;
  localparam int SPI_FIRST_RO_ADDR = 4;

endpackage

`default_nettype wire

// File: rtl/spi_sclk_gen.sv
// +--------------------------------------------------------------------------+
// | spi_sclk_gen : CLK_DIV half-period divider producing sclk + edge strobes |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic iclk,
  input  logic rstn,
  input  logic i_en,
  output logic o_sclk,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [7:0] c_div_last = 8'(CLK_DIV - 1);

  logic [7:0] r_cnt;
  logic       r_sclk;
  logic       w_toggle;

  assign w_toggle = i_en && (r_cnt == c_div_last);

  // Strobes are high in the cycle whose closing edge moves sclk.
  assign o_rise = w_toggle && !r_sclk;
  assign o_fall = w_toggle && r_sclk;
  assign o_sclk = r_sclk;

  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) begin
      r_cnt  <= 8'd0;
      r_sclk <= 1'b0;
    end else if (!i_en) begin
      r_cnt  <= 8'd0;
      r_sclk <= 1'b0;
    end else if (w_toggle) begin
      r_cnt  <= 8'd0;
      r_sclk <= ~r_sclk;
    end else begin
      r_cnt  <= r_cnt + 8'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_controller.sv
// +--------------------------------------------------------------------------+
// | spi_controller : SPI mode-0 initiator, address byte + len data bytes     |
// | Optional macro SPI_CTRL_LOOPBACK_EN adds a pico->receiver loopback port. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module spi_controller
  import spi_ctrl_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int IDLE_GAP = 16
) (
  input  logic              iclk,
  input  logic              rstn,
  input  logic              start,
  input  logic [BYTE_W-1:0] addr,
  input  logic [BYTE_W-1:0] len,
  input  logic [BYTE_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [BYTE_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              pico,
`ifdef SPI_CTRL_LOOPBACK_EN
  input  logic              loopback,
`endif
  input  logic              poci
);

  localparam int                GAP_W      = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
  localparam logic [GAP_W-1:0]  c_gap_last = GAP_W'(IDLE_GAP - 1);

  state_t              r_state;
  state_t              w_next;
  logic                w_rise;
  logic                w_fall;
  logic                w_sclk_en;
  logic                w_byte_end;
  logic                w_wr_ready;
  logic                w_done;
  logic                w_rx_bit;
  logic [2:0]          r_bit;
  logic [BYTE_W-1:0]   r_bytes_left;
  logic [GAP_W-1:0]    r_gap;
  logic [BYTE_W-1:0]   r_tx;
  logic [BYTE_W-2:0]   r_rx;
  logic [BYTE_W-1:0]   r_rd_data;
  logic                r_rd_valid;

  assign w_sclk_en = (r_state == ADDR) || (r_state == DATA);

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .iclk   (iclk),
    .rstn   (rstn),
    .i_en   (w_sclk_en),
    .o_sclk (sclk),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  // Bits are counted on rise; the counter wraps to 0 on the 8th, so the
  // fall that follows closes the byte.
  assign w_byte_end = w_fall && (r_bit == 3'd0);

`ifdef SPI_CTRL_LOOPBACK_EN
  assign w_rx_bit = loopback ? r_tx[BYTE_W-1] : poci;
`else
  assign w_rx_bit = poci;
`endif

  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_wr_ready = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      IDLE: if (start) w_next = ADDR;
      ADDR: begin
        if (w_byte_end) begin
          if (r_bytes_left != '0) begin
            w_next     = DATA;
            w_wr_ready = 1'b1;
          end else begin
            w_next     = GAP;
          end
        end
      end
      DATA: begin
        if (w_byte_end) begin
          if (r_bytes_left == BYTE_W'(1)) w_next     = GAP;
          else                            w_wr_ready = 1'b1;
        end
      end
      GAP: begin
        if (r_gap == c_gap_last) begin
          w_done = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) begin
      r_bit        <= 3'd0;
      r_bytes_left <= '0;
      r_gap        <= '0;
      r_tx         <= '0;
      r_rx         <= '0;
      r_rd_data    <= '0;
      r_rd_valid   <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_tx         <= addr;
            r_bytes_left <= len;
            r_bit        <= 3'd0;
            r_gap        <= '0;
          end
        end
        ADDR, DATA: begin
          if (w_rise) r_bit <= r_bit + 3'd1;
          if (w_fall) begin
            r_rx <= {r_rx[BYTE_W-3:0], w_rx_bit};
            if (w_byte_end) begin
              // Clearing the shifter on the last byte keeps pico low in GAP.
              r_tx <= w_wr_ready ? wr_data : '0;
              if (r_state == DATA) begin
                r_rd_data    <= {r_rx, w_rx_bit};
                r_rd_valid   <= 1'b1;
                r_bytes_left <= r_bytes_left - BYTE_W'(1);
              end
            end else begin
              r_tx <= {r_tx[BYTE_W-2:0], 1'b0};
            end
          end
        end
        GAP:     r_gap <= r_gap + GAP_W'(1);
        default: ;
      endcase
    end
  end

  assign pico     = r_tx[BYTE_W-1];
  assign busy     = (r_state != IDLE);
  assign done     = w_done;
  assign wr_ready = w_wr_ready;
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;

endmodule

`default_nettype wire
